alu_multicycle: RTL and testbench

ALU_MULTICYCLE -- requirements
Module: alu_multicycle

---
 rtl/alu_multicycle.sv | 142 ++++++++++++++
 tb/tb_alu_multicycle.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/alu_multicycle.sv
// Multi-cycle ALU: single-cycle ADD/SUB/AND/OR/SLT/NOP, iterative shift-add MUL and
// restoring DIV. Define ALU_DIV_EN to build the divider; otherwise OP 6 returns 0.
module alu_multicycle #(
  parameter int WIDTH = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic [2:0]       OP,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] RESULT,
  output logic             ZERO,
  output logic             BUSY,
  output logic             DONE,
  output logic             DIV_BY_ZERO
);
  localparam logic [2:0] OP_ADD = 3'd0, OP_SUB = 3'd1, OP_AND = 3'd2, OP_OR  = 3'd3,
                         OP_SLT = 3'd4, OP_MUL = 3'd5, OP_DIV = 3'd6;
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] acc, opa, opb;
  logic [WIDTH-1:0] quick, step_acc, step_opa, step_opb, step_res;
  logic             busy, done, dbz, go_iter, go_dbz;
`ifdef ALU_DIV_EN
  logic             is_div, rem_ge;
  logic [WIDTH:0]   rem_sh;
`endif

  always_comb begin
    go_iter = (OP == OP_MUL);
    go_dbz  = 1'b0;
`ifdef ALU_DIV_EN
    if (OP == OP_DIV) begin
      go_iter = (B != '0);
      go_dbz  = (B == '0);
    end
`endif
  end

  // Single-cycle result; DIV only lands here when B == 0 (or divider absent).
  always_comb begin
    quick = RESULT;
    case (OP)
      OP_ADD:  quick = A + B;
      OP_SUB:  quick = A - B;
      OP_AND:  quick = A & B;
      OP_OR:   quick = A | B;
      OP_SLT:  quick = WIDTH'($signed(A) < $signed(B));
`ifdef ALU_DIV_EN
      OP_DIV:  quick = '1;
`else
      OP_DIV:  quick = '0;
`endif
      default: quick = RESULT;
    endcase
  end

  // One iteration: acc is the product / partial remainder, opa the shifted
  // multiplicand / dividend-becoming-quotient, opb the multiplier / divisor.
  always_comb begin
    step_acc = acc + (opb[0] ? opa : '0);
    step_opa = opa << 1;
    step_opb = opb >> 1;
    step_res = step_acc;
`ifdef ALU_DIV_EN
    rem_sh = {acc, opa[WIDTH-1]};
    rem_ge = (rem_sh >= {1'b0, opb});
    if (is_div) begin
      step_acc = rem_ge ? WIDTH'(rem_sh - {1'b0, opb}) : rem_sh[WIDTH-1:0];
      step_opa = {opa[WIDTH-2:0], rem_ge};
      step_opb = opb;
      step_res = step_opa;
    end
`endif
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state  <= IDLE;
      cnt    <= '0;
      acc    <= '0;
      opa    <= '0;
      opb    <= '0;
      RESULT <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      dbz    <= 1'b0;
`ifdef ALU_DIV_EN
      is_div <= 1'b0;
`endif
    end else begin
      case (state)
        RUN: begin
          cnt <= cnt + 1'b1;
          acc <= step_acc;
          opa <= step_opa;
          opb <= step_opb;
          if (cnt == CW'(WIDTH-1)) begin
            state  <= FIN;
            RESULT <= step_res;
            busy   <= 1'b0;
            done   <= 1'b1;
          end
        end
        default: begin
          if (START) begin
            cnt <= '0;
            dbz <= go_dbz;
            if (go_iter) begin
              state <= RUN;
              acc   <= '0;
              opa   <= A;
              opb   <= B;
              busy  <= 1'b1;
              done  <= 1'b0;
`ifdef ALU_DIV_EN
              is_div <= (OP == OP_DIV);
`endif
            end else begin
              state  <= FIN;
              RESULT <= quick;
              done   <= 1'b1;
            end
          end else begin
            state <= IDLE;
            done  <= 1'b0;
          end
        end
      endcase
    end
  end

  assign ZERO        = (RESULT == '0);
  assign BUSY        = busy;
  assign DONE        = done;
  assign DIV_BY_ZERO = dbz;
endmodule

// File: tb/tb_alu_multicycle.sv
// Bench for alu_multicycle (WIDTH=32): vector table, multi-cycle corner cases and
// random ops against an arithmetic reference; expectations follow ALU_DIV_EN.
module tb_alu_multicycle;
  localparam int W = 32;

  logic          CLK = 1'b0, RST = 1'b1, START = 1'b0;
  logic [2:0]    OP = '0;
  logic [W-1:0]  A = '0, B = '0;
  logic [W-1:0]  RESULT;
  logic          ZERO, BUSY, DONE, DIV_BY_ZERO;

  int pass_cnt = 0, tot_cnt = 0;
  logic [W-1:0] prev_res = '0;

  alu_multicycle #(.WIDTH(W)) dut (
    .CLK(CLK), .RST(RST), .START(START), .OP(OP), .A(A), .B(B),
    .RESULT(RESULT), .ZERO(ZERO), .BUSY(BUSY), .DONE(DONE), .DIV_BY_ZERO(DIV_BY_ZERO)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [2:0]   op;
    logic [W-1:0] a, b, res;
    logic         dbz;
    int           lat;
  } vec_t;

  vec_t tbl[12];

`ifdef ALU_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tot_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
  endtask

  // Reference: plain arithmetic on the operation's meaning.
  task automatic ref_model(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                           output logic [W-1:0] res, output logic dbz, output int lat);
    longint unsigned prod;
    dbz = 1'b0;
    lat = 1;
    case (op)
      3'd0: res = W'(longint'(a) + longint'(b));
      3'd1: res = W'(longint'(a) - longint'(b));
      3'd2: res = a & b;
      3'd3: res = a | b;
      3'd4: res = (int'(a) < int'(b)) ? 1 : 0;
      3'd5: begin prod = longint'(a) * longint'(b); res = W'(prod); lat = W + 1; end
      3'd6: begin
        if (!DIV_EN) res = '0;
        else if (b == 0) begin res = '1; dbz = 1'b1; end
        else begin res = a / b; lat = W + 1; end
      end
      default: res = prev_res;
    endcase
  endtask

  // Issue one request, then follow it to DONE and one cycle beyond.
  task automatic run_op(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] er, input logic edbz, input int elat, input string nm);
    int n, busy_n;
    bit stable;
    @(negedge CLK);
    START = 1'b1; OP = op; A = a; B = b;
    @(negedge CLK);
    START = 1'b0; OP = 3'($urandom); A = $urandom; B = $urandom;
    n = 1; busy_n = 0; stable = 1'b1;
    while (!DONE && n < 100) begin
      if (BUSY) busy_n++;
      if (RESULT !== prev_res) stable = 1'b0;
      @(negedge CLK);
      n++;
    end
    check({nm, ".lat"}, n, elat);
    check({nm, ".busy_cycles"}, busy_n, (elat > 1) ? W : 0);
    check({nm, ".stable"}, stable, 1);
    check({nm, ".result"}, RESULT, er);
    check({nm, ".zero"}, ZERO, er == 0);
    check({nm, ".dbz"}, DIV_BY_ZERO, edbz);
    @(negedge CLK);
    check({nm, ".done_drop"}, DONE, 0);
    check({nm, ".dbz_hold"}, DIV_BY_ZERO, edbz);
    prev_res = er;
  endtask

  initial begin
    logic [W-1:0] r, ra, rb;
    logic         d;
    int           l, n, dn;
    logic [2:0]   rop;

    tbl[0]  = '{3'd0, 32'd5,          32'd7,          32'd12,         1'b0, 1};
    tbl[1]  = '{3'd4, 32'hFFFF_FFFF,  32'd1,          32'd1,          1'b0, 1};
    tbl[2]  = '{3'd1, 32'd3,          32'd3,          32'd0,          1'b0, 1};
    tbl[3]  = '{3'd5, 32'd123,        32'd456,        32'd56088,      1'b0, W + 1};
    tbl[4]  = '{3'd5, 32'h0001_0000,  32'h0001_0000,  32'd0,          1'b0, W + 1};
    tbl[5]  = '{3'd2, 32'hF0F0_F0F0,  32'hFF00_FF00,  32'hF000_F000,  1'b0, 1};
    tbl[6]  = '{3'd3, 32'h0000_00F0,  32'h0000_000F,  32'h0000_00FF,  1'b0, 1};
    tbl[7]  = '{3'd7, 32'd1,          32'd2,          32'h0000_00FF,  1'b0, 1};
    tbl[8]  = '{3'd4, 32'd1,          32'hFFFF_FFFF,  32'd0,          1'b0, 1};
    tbl[9]  = '{3'd1, 32'd0,          32'd1,          32'hFFFF_FFFF,  1'b0, 1};
    if (DIV_EN) begin
      tbl[10] = '{3'd6, 32'd100, 32'd7, 32'd14,         1'b0, W + 1};
      tbl[11] = '{3'd6, 32'd9,   32'd0, 32'hFFFF_FFFF,  1'b1, 1};
    end else begin
      tbl[10] = '{3'd6, 32'd100, 32'd7, 32'd0,          1'b0, 1};
      tbl[11] = '{3'd6, 32'd9,   32'd0, 32'd0,          1'b0, 1};
    end

    // Reset state
    repeat (2) @(negedge CLK);
    check("rst.result", RESULT, 0);
    check("rst.zero", ZERO, 1);
    check("rst.busy", BUSY, 0);
    check("rst.done", DONE, 0);
    check("rst.dbz", DIV_BY_ZERO, 0);
    RST = 1'b0;

    foreach (tbl[i])
      run_op(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].res, tbl[i].dbz, tbl[i].lat,
             $sformatf("vec%0d", i));

    // START during MUL busy must be ignored
    @(negedge CLK);
    START = 1'b1; OP = 3'd5; A = 32'd123; B = 32'd456;
    @(negedge CLK);
    START = 1'b0; n = 1;
    repeat (4) begin @(negedge CLK); n++; end
    START = 1'b1; OP = 3'd0; A = 32'd1; B = 32'd1;
    @(negedge CLK); n++;
    START = 1'b0;
    while (!DONE && n < 100) begin @(negedge CLK); n++; end
    check("ignore.lat", n, W + 1);
    check("ignore.result", RESULT, 56088);
    @(negedge CLK);
    check("ignore.done_drop", DONE, 0);
    prev_res = 32'd56088;

    // Reset at edge k+10 of a MUL aborts with no DONE
    @(negedge CLK);
    START = 1'b1; OP = 3'd5; A = 32'd7; B = 32'd9;
    @(negedge CLK);
    START = 1'b0;
    repeat (9) @(negedge CLK);
    check("abort.busy_before", BUSY, 1);
    RST = 1'b1;
    @(negedge CLK);
    check("abort.result", RESULT, 0);
    check("abort.zero", ZERO, 1);
    check("abort.busy", BUSY, 0);
    check("abort.done", DONE, 0);
    check("abort.dbz", DIV_BY_ZERO, 0);
    RST = 1'b0;
    dn = 0;
    repeat (40) begin @(negedge CLK); if (DONE) dn++; end
    check("abort.no_done", dn, 0);
    prev_res = '0;

    // Back-to-back: ADD accepted on the MUL's FIN edge
    @(negedge CLK);
    START = 1'b1; OP = 3'd5; A = 32'd3; B = 32'd4;
    @(negedge CLK);
    OP = 3'd0; A = 32'd1; B = 32'd1; n = 1;
    while (!DONE && n < 100) begin @(negedge CLK); n++; end
    check("b2b.mul_lat", n, W + 1);
    check("b2b.mul_result", RESULT, 12);
    @(negedge CLK);
    START = 1'b0;
    check("b2b.add_done", DONE, 1);
    check("b2b.add_result", RESULT, 2);
    @(negedge CLK);
    check("b2b.done_drop", DONE, 0);
    prev_res = 32'd2;

    // Randomised ops against the reference model
    for (int i = 0; i < 30; i++) begin
      rop = 3'($urandom_range(0, 7));
      ra  = $urandom;
      rb  = ($urandom_range(0, 3) == 0) ? '0 : $urandom;
      if ($urandom_range(0, 3) == 0) ra = ra >> $urandom_range(0, 31);
      ref_model(rop, ra, rb, r, d, l);
      run_op(rop, ra, rb, r, d, l, $sformatf("rnd%0d.op%0d", i, rop));
    end

    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end
endmodule
